// File: rtl/muldiv_pkg.sv
// Shared types and opcode constants for the EX-stage iterative multiply/divide unit.
// The divider ops are only recognised when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // True for ops that run the XLEN-step datapath; anything else completes at once with result 0.
  function automatic logic op_iterates(input logic [9:0] funct);
    logic [2:0] f3;
    f3 = funct[2:0];
    if (funct[9:3] != FUNCT7_MULDIV) return 1'b0;
`ifdef MULDIV_DIV_EN
    return f3 inside {F3_MUL, F3_MULHU, F3_DIVU, F3_REMU};
`else
    return f3 inside {F3_MUL, F3_MULHU};
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side request and EX/MEM-side response bundle of the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            kill_i;
  logic [9:0]      funct_i;
  logic [XLEN-1:0] data1_i;
  logic [XLEN-1:0] data2_i;
  logic [4:0]      RDaddr_i;
  logic            stall_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      RDaddr_o;

  modport master (
    output start_i, kill_i, funct_i, data1_i, data2_i, RDaddr_i,
    input  stall_o, result_valid_o, result_o, RDaddr_o
  );

  modport slave (
    input  start_i, kill_i, funct_i, data1_i, data2_i, RDaddr_i,
    output stall_o, result_valid_o, result_o, RDaddr_o
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: one shift-add (multiply) or restoring-subtract (divide) step per i_step.
// The divide half exists only when MULDIV_DIV_EN is defined.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              i_load,
  input  logic              i_step,
`ifdef MULDIV_DIV_EN
  input  logic              i_is_div,
  output logic [XLEN-1:0]   o_quot_nxt,
  output logic [XLEN-1:0]   o_rem_nxt,
`endif
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_prod_nxt
);

  // r_acc holds {partial product, multiplier} or, for divide, the dividend/quotient in its low half.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN:0]     w_sum;

  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
  assign o_prod_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] r_rem;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // A zero divisor always compares as fitting: quotient becomes all ones, remainder the dividend.
  assign w_trial    = {r_rem, r_acc[XLEN-1]};
  assign w_ge       = w_trial >= {1'b0, r_opb};
  assign w_diff     = w_trial[XLEN-1:0] - r_opb;
  assign o_rem_nxt  = w_ge ? w_diff : w_trial[XLEN-1:0];
  assign o_quot_nxt = {r_acc[XLEN-2:0], w_ge};
`endif

  // NOTE: datapath registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk_i) begin
    if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_a};
      r_opb <= i_b;
`ifdef MULDIV_DIV_EN
      r_rem <= '0;
`endif
    end else if (i_step) begin
`ifdef MULDIV_DIV_EN
      if (i_is_div) begin
        r_acc[XLEN-1:0] <= o_quot_nxt;
        r_rem           <= o_rem_nxt;
      end else begin
        r_acc <= o_prod_nxt;
      end
`else
      r_acc <= o_prod_nxt;
`endif
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative unsigned MUL/MULHU (and DIVU/REMU with MULDIV_DIV_EN): FSM, counter,
// capture registers and pipeline stall; the arithmetic lives in muldiv_iter_core.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  ex_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_valid;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_accept;
  logic              w_busy;
  logic              w_last;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN-1:0]   w_final;
`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0]   w_quot_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
`endif

  assign w_accept = (r_state == IDLE) & bus.start_i & ~bus.kill_i;
  assign w_busy   = (r_state == BUSY);
  assign w_last   = w_busy & (r_cnt == CNT_W'(XLEN - 1));

  assign bus.stall_o        = w_accept | w_busy;
  assign bus.result_valid_o = r_valid;
  assign bus.result_o       = r_result;
  assign bus.RDaddr_o       = r_rd_out;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk_i      (clk_i),
    .i_load     (w_accept),
    .i_step     (w_busy),
`ifdef MULDIV_DIV_EN
    .i_is_div   (r_funct3[2]),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt),
`endif
    .i_a        (bus.data1_i),
    .i_b        (bus.data2_i),
    .o_prod_nxt (w_prod_nxt)
  );

  // The final step and the result capture share one edge, so select from the core's next values.
  always_comb begin
    // NOTE: the default assignment comes first so no path leaves w_final unassigned (no latch).
    w_final = '0;
    case (r_funct3)
      F3_MUL:   w_final = w_prod_nxt[XLEN-1:0];
      F3_MULHU: w_final = w_prod_nxt[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      F3_DIVU:  w_final = w_quot_nxt;
      F3_REMU:  w_final = w_rem_nxt;
`endif
      default:  w_final = '0;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from its pre-edge value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= bus.funct_i[2:0];
            r_rd     <= bus.RDaddr_i;
            if (op_iterates(bus.funct_i)) begin
              r_state <= BUSY;
            end else begin
              r_state  <= DONE;
              r_valid  <= 1'b1;
              r_result <= '0;
              r_rd_out <= bus.RDaddr_i;
            end
          end
        end
        BUSY: begin
          if (bus.kill_i) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state  <= DONE;
              r_valid  <= 1'b1;
              r_result <= w_final;
              r_rd_out <= r_rd;
            end
          end
        end
        // start_i still shows the finished instruction here, so it is ignored.
        DONE: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
